nasti_mem_bridge: RTL and testbench
===================================

# nasti_mem_bridge

Converts a simple single-word memory request/response port into single-beat NASTI (AXI4) transactions. It is the master stage that drives the AW/W/AR channels of the behavioural NASTI RAM and consumes its B/R channels. It lets a core-side or test-side agent reach memory without handling AXI channel ordering. Exactly one transaction is outstanding at a time.

## Interface
- ID_WIDTH, 1, NASTI id width; all issued ids are 0
- ADDR_WIDTH, 16, request/NASTI address width
- DATA_WIDTH, 128, word width; one beat per request
- USER_WIDTH, 1, NASTI user width; user driven 0
- clk  in  1  clock; all logic on posedge
- rstn  in  1  reset, synchronous, active-low
- req_valid / req_ready  in / out  1  request handshake
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  write data
- req_strb  in  DATA_WIDTH/8  write byte enables
- rsp_valid / rsp_ready  out / in  1  response handshake
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
- rsp_err  out  1  1 = SLVERR/DECERR or protocol error
- aw, w, ar  nasti_aw.master / nasti_w.master / nasti_ar.master  write address, write data, read address
- b, r  nasti_b.master / nasti_r.master  write response, read data

## Operation
- FSM states: IDLE, WR (AW and W outstanding), WR_B, RD_AR, RD_R, RSP.
- IDLE: req_ready=1. On req_valid&req_ready, capture the request. Go to WR if req_we, else RD_AR.
- Captured address has its low log2(DATA_WIDTH/8) bits cleared, so issued addresses are beat-aligned.
- Issued fields: len=0, size=log2(DATA_WIDTH/8), burst=INCR (2'b01), id=0, user=0. All other sideband fields are 0. w.last=1.
- WR: aw.valid and w.valid assert together. Each drops independently on its own handshake; per-channel "done" flags track this. If both handshakes occur in the same cycle, go to WR_B next cycle.
  - Whichever channel completes first keeps valid low afterward; valid never reasserts.
- WR_B: b.ready=1. On b handshake, rsp_err = b.resp[1] | (b.id != 0). Go to RSP.
- RD_AR: ar.valid=1 until ar.ready, then go to RD_R.
- RD_R: r.ready=1. On r handshake, capture r.data into rsp_rdata. rsp_err = r.resp[1] | !r.last | (r.id != 0). Go to RSP.
- RSP: rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_ready, then return to IDLE.
- b.ready is 0 outside WR_B; r.ready is 0 outside RD_R. A stray B or R beat is left stalled, never consumed.
- rsp_rdata is zero on write responses.

## Timing
- Reset (rstn=0 at posedge): state=IDLE. At the next edge, aw.valid, w.valid, ar.valid, b.ready, r.ready, rsp_valid, rsp_err and rsp_rdata are all 0. req_ready=1 from the first cycle after reset.
- All NASTI valid/ready outputs and rsp_* are registered or decoded purely from state. There are no combinational paths from NASTI inputs to NASTI outputs.
- req accepted at cycle 0 → aw/w/ar valid at cycle 1.
- Minimum latency, with ready in the same cycle and a response one cycle later:
  - write: cycle 0 accept, 1 AW/W, 2 B, 3 rsp_valid.
  - read: cycle 0 accept, 1 AR, 2 R, 3 rsp_valid.
- Back-to-back: a request can be accepted no earlier than the cycle after the rsp handshake. Throughput is at most 1 transaction per 4 cycles.
- Valid-stability rule: once asserted, aw/w/ar/rsp valid and payload hold until handshake.
- Reset mid-transaction: the transaction is abandoned and all outputs return to reset values. Memory must be reset together with the bridge.

## Structure
- Shared package nasti_bridge_pkg:
  - state enum
  - NASTI constants: BURST_INCR=2'b01, RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11
  - function for size from DATA_WIDTH
- Single flat module; no sub-module needed.
- Elaboration checks: DATA_WIDTH is a power of two ≥ 8; ADDR_WIDTH ≤ 32.

## Test plan
- Write addr 0x0010, wdata 0xA5…A5, strb all ones; then read 0x0010 → read rsp_rdata 0xA5…A5, rsp_err=0.
- Write 0x0020 with strb=16'h0001, data 0x…FF, over prior all-zero memory; then read → only byte 0 = 0xFF.
- Unaligned req_addr 0x0013 → aw.addr = 0x0010.
- AW ready delayed 3 cycles while W is accepted immediately → w.valid drops after 1 cycle, exactly one W beat, one rsp.
- Memory returns SLVERR on B → rsp_err=1. Separately, a read with r.last=0 → rsp_err=1.
- rsp_ready held low 5 cycles → rsp_valid/rsp_rdata stable and req_ready=0 throughout. Separately, rstn=0 while in RD_R → all valids 0 next cycle, req_ready=1 after release.

Source files
------------

// File: rtl/nasti_bridge_pkg.sv
// Shared types and NASTI constants for the single-beat memory-to-NASTI bridge.
package nasti_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_B,
        RD_AR,
        RD_R,
        RSP
    } state_t;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // AxSIZE encoding for one full data-bus beat.
    function automatic logic [2:0] nasti_size(input int unsigned data_width);
        return 3'($clog2(data_width / 8));
    endfunction

endpackage

// File: rtl/nasti_mem_bridge_if.sv
// NASTI channel interfaces; master modports face the bridge, slave modports face memory.
interface nasti_aw #(
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 16,
    parameter int USER_WIDTH = 1
);
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic                  lock;
    logic [3:0]            cache;
    logic [2:0]            prot;
    logic [3:0]            qos;
    logic [3:0]            region;
    logic [USER_WIDTH-1:0] user;
    logic                  valid;
    logic                  ready;

    modport master (output id, addr, len, size, burst, lock, cache, prot, qos, region, user, valid,
                    input ready);
    modport slave  (input id, addr, len, size, burst, lock, cache, prot, qos, region, user, valid,
                    output ready);
endinterface

interface nasti_w #(
    parameter int DATA_WIDTH = 128,
    parameter int USER_WIDTH = 1
);
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] strb;
    logic                    last;
    logic [USER_WIDTH-1:0]   user;
    logic                    valid;
    logic                    ready;

    modport master (output data, strb, last, user, valid, input ready);
    modport slave  (input data, strb, last, user, valid, output ready);
endinterface

interface nasti_ar #(
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 16,
    parameter int USER_WIDTH = 1
);
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic                  lock;
    logic [3:0]            cache;
    logic [2:0]            prot;
    logic [3:0]            qos;
    logic [3:0]            region;
    logic [USER_WIDTH-1:0] user;
    logic                  valid;
    logic                  ready;

    modport master (output id, addr, len, size, burst, lock, cache, prot, qos, region, user, valid,
                    input ready);
    modport slave  (input id, addr, len, size, burst, lock, cache, prot, qos, region, user, valid,
                    output ready);
endinterface

interface nasti_b #(
    parameter int ID_WIDTH   = 1,
    parameter int USER_WIDTH = 1
);
    logic [ID_WIDTH-1:0]   id;
    logic [1:0]            resp;
    logic [USER_WIDTH-1:0] user;
    logic                  valid;
    logic                  ready;

    modport master (input id, resp, user, valid, output ready);
    modport slave  (output id, resp, user, valid, input ready);
endinterface

interface nasti_r #(
    parameter int ID_WIDTH   = 1,
    parameter int DATA_WIDTH = 128,
    parameter int USER_WIDTH = 1
);
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
    logic [1:0]            resp;
    logic                  last;
    logic [USER_WIDTH-1:0] user;
    logic                  valid;
    logic                  ready;

    modport master (input id, data, resp, last, user, valid, output ready);
    modport slave  (output id, data, resp, last, user, valid, input ready);
endinterface

// File: rtl/nasti_mem_bridge.sv
// Turns one-word request/response transfers into single-beat NASTI transactions,
// one outstanding at a time. Handshake outputs decode from registered state only.
module nasti_mem_bridge
    import nasti_bridge_pkg::*;
#(
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 128,
    parameter int USER_WIDTH = 1
) (
    input  logic                    clk,
    input  logic                    rstn,

    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_strb,

    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,

    nasti_aw.master                 aw,
    nasti_w.master                  w,
    nasti_ar.master                 ar,
    nasti_b.master                  b,
    nasti_r.master                  r
);

    localparam int              STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [2:0]      BEAT_SIZE  = nasti_size(DATA_WIDTH);
    localparam [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(STRB_WIDTH - 1);

    if ((DATA_WIDTH < 8) || ((DATA_WIDTH & (DATA_WIDTH - 1)) != 0)) begin : g_bad_data_width
        $error("nasti_mem_bridge: DATA_WIDTH must be a power of two >= 8");
    end
    if (ADDR_WIDTH > 32) begin : g_bad_addr_width
        $error("nasti_mem_bridge: ADDR_WIDTH must not exceed 32");
    end

    state_t                  state_reg, state_next;
    logic                    aw_done_reg, aw_done_next;
    logic                    w_done_reg, w_done_next;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
    logic [DATA_WIDTH-1:0]   wdata_reg, wdata_next;
    logic [STRB_WIDTH-1:0]   strb_reg, strb_next;
    logic [DATA_WIDTH-1:0]   rdata_reg, rdata_next;
    logic                    err_reg, err_next;

    logic                    aw_fire, w_fire;
    logic                    unused_inputs;

    assign aw_fire       = aw.valid && aw.ready;
    assign w_fire        = w.valid && w.ready;
    assign unused_inputs = ^{b.user, r.user};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg   <= IDLE;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            strb_reg    <= '0;
            rdata_reg   <= '0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            aw_done_reg <= aw_done_next;
            w_done_reg  <= w_done_next;
            addr_reg    <= addr_next;
            wdata_reg   <= wdata_next;
            strb_reg    <= strb_next;
            rdata_reg   <= rdata_next;
            err_reg     <= err_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        aw_done_next = aw_done_reg;
        w_done_next  = w_done_reg;
        addr_next    = addr_reg;
        wdata_next   = wdata_reg;
        strb_next    = strb_reg;
        rdata_next   = rdata_reg;
        err_next     = err_reg;

        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    addr_next    = req_addr & ALIGN_MASK;
                    wdata_next   = req_wdata;
                    strb_next    = req_strb;
                    rdata_next   = '0;
                    err_next     = 1'b0;
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
                    state_next   = req_we ? WR : RD_AR;
                end
            end
            WR: begin
                // AW and W retire independently; leave only once both are done.
                aw_done_next = aw_done_reg | aw_fire;
                w_done_next  = w_done_reg | w_fire;
                if ((aw_done_reg | aw_fire) && (w_done_reg | w_fire)) begin
                    state_next = WR_B;
                end
            end
            WR_B: begin
                if (b.valid) begin
                    err_next   = b.resp[1] | (b.id != '0);
                    state_next = RSP;
                end
            end
            RD_AR: begin
                if (ar.ready) begin
                    state_next = RD_R;
                end
            end
            RD_R: begin
                if (r.valid) begin
                    rdata_next = r.data;
                    err_next   = r.resp[1] | !r.last | (r.id != '0);
                    state_next = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign req_ready = (state_reg == IDLE);
    assign rsp_valid = (state_reg == RSP);
    assign rsp_rdata = rdata_reg;
    assign rsp_err   = err_reg;

    assign aw.valid  = (state_reg == WR) && !aw_done_reg;
    assign aw.id     = '0;
    assign aw.addr   = addr_reg;
    assign aw.len    = 8'd0;
    assign aw.size   = BEAT_SIZE;
    assign aw.burst  = BURST_INCR;
    assign aw.lock   = 1'b0;
    assign aw.cache  = 4'd0;
    assign aw.prot   = 3'd0;
    assign aw.qos    = 4'd0;
    assign aw.region = 4'd0;
    assign aw.user   = '0;

    assign w.valid   = (state_reg == WR) && !w_done_reg;
    assign w.data    = wdata_reg;
    assign w.strb    = strb_reg;
    assign w.last    = 1'b1;
    assign w.user    = '0;

    assign ar.valid  = (state_reg == RD_AR);
    assign ar.id     = '0;
    assign ar.addr   = addr_reg;
    assign ar.len    = 8'd0;
    assign ar.size   = BEAT_SIZE;
    assign ar.burst  = BURST_INCR;
    assign ar.lock   = 1'b0;
    assign ar.cache  = 4'd0;
    assign ar.prot   = 3'd0;
    assign ar.qos    = 4'd0;
    assign ar.region = 4'd0;
    assign ar.user   = '0;

    // Stray B/R beats outside their wait states stay stalled.
    assign b.ready   = (state_reg == WR_B);
    assign r.ready   = (state_reg == RD_R);

endmodule

// File: tb/tb_nasti_mem_bridge.sv
// Bench for nasti_mem_bridge: behavioural NASTI RAM with delay/error knobs and a
// word-level reference memory that predicts every response.
module tb_nasti_mem_bridge;
    import nasti_bridge_pkg::*;

    localparam int IDW = 1;
    localparam int AW  = 16;
    localparam int DW  = 128;
    localparam int UW  = 1;
    localparam int SW  = DW / 8;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we    = 1'b0;
    logic [AW-1:0] req_addr  = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [SW-1:0] req_strb  = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    nasti_aw #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .USER_WIDTH(UW)) aw_if ();
    nasti_w  #(.DATA_WIDTH(DW), .USER_WIDTH(UW))                 w_if ();
    nasti_ar #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .USER_WIDTH(UW)) ar_if ();
    nasti_b  #(.ID_WIDTH(IDW), .USER_WIDTH(UW))                  b_if ();
    nasti_r  #(.ID_WIDTH(IDW), .DATA_WIDTH(DW), .USER_WIDTH(UW)) r_if ();

    nasti_mem_bridge #(
        .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .USER_WIDTH(UW)
    ) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .aw(aw_if), .w(w_if), .ar(ar_if), .b(b_if), .r(r_if)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference memory: word array updated by strobed writes.
    logic [DW-1:0] ref_mem [0:4095];

    function automatic void ref_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        logic [DW-1:0] m;
        for (int i = 0; i < SW; i++) m[8*i +: 8] = {8{s[i]}};
        ref_mem[a[15:4]] = (ref_mem[a[15:4]] & ~m) | (d & m);
    endfunction

    // Memory-side model: knobs, storage and observation counters.
    int          aw_delay = 0, w_delay = 0, ar_delay = 0;
    logic [1:0]  b_resp_cfg = RESP_OKAY, r_resp_cfg = RESP_OKAY;
    logic        r_last_cfg = 1'b1, b_id_cfg = 1'b0, r_hold = 1'b0;
    logic [DW-1:0] sl_mem [0:4095];
    logic        aw_vq, w_vq, ar_vq, b_rq, r_rq, aw_have, w_have, ar_have;
    logic [AW-1:0] aw_addr_q, ar_addr_q, aw_addr_h, ar_addr_h, last_aw_addr, last_ar_addr;
    logic [DW-1:0] wd_q, wd_h;
    logic [SW-1:0] ws_q, ws_h;
    int          aw_wait, w_wait, ar_wait;
    int unsigned n_w = 0, n_b = 0, n_r = 0, aw_vcyc = 0, w_vcyc = 0, viol = 0;

    initial begin
        for (int i = 0; i < 4096; i++) begin
            sl_mem[i]  = '0;
            ref_mem[i] = '0;
        end
    end

    always @(negedge clk) begin
        if (!rstn) begin
            aw_if.ready = 0; w_if.ready = 0; ar_if.ready = 0;
            b_if.valid = 0; b_if.id = 0; b_if.resp = 0; b_if.user = 0;
            r_if.valid = 0; r_if.id = 0; r_if.data = 0; r_if.resp = 0; r_if.last = 0; r_if.user = 0;
            aw_vq = 0; w_vq = 0; ar_vq = 0; b_rq = 0; r_rq = 0;
            aw_have = 0; w_have = 0; ar_have = 0; aw_wait = 0; w_wait = 0; ar_wait = 0;
        end else begin
            if (aw_vq && aw_if.ready) begin aw_have = 1; aw_addr_h = aw_addr_q; last_aw_addr = aw_addr_q; end
            if (w_vq && w_if.ready)   begin w_have = 1; wd_h = wd_q; ws_h = ws_q; n_w++; end
            if (ar_vq && ar_if.ready) begin ar_have = 1; ar_addr_h = ar_addr_q; last_ar_addr = ar_addr_q; end
            if (b_if.valid && b_rq)   begin b_if.valid = 0; n_b++; end
            if (r_if.valid && r_rq)   begin r_if.valid = 0; n_r++; end
            if (aw_have && w_have && !b_if.valid) begin
                for (int i = 0; i < SW; i++)
                    if (ws_h[i]) sl_mem[aw_addr_h[15:4]][8*i +: 8] = wd_h[8*i +: 8];
                b_if.valid = 1; b_if.resp = b_resp_cfg; b_if.id = b_id_cfg;
                aw_have = 0; w_have = 0;
            end
            if (ar_have && !r_if.valid && !r_hold) begin
                r_if.valid = 1; r_if.data = sl_mem[ar_addr_h[15:4]];
                r_if.resp = r_resp_cfg; r_if.last = r_last_cfg; r_if.id = 0;
                ar_have = 0;
            end
            if (aw_if.valid) begin
                aw_vcyc++;
                if (aw_if.len != 0 || aw_if.size != 3'd4 || aw_if.burst != 2'b01 || aw_if.addr[3:0] != 0 ||
                    aw_if.lock || aw_if.cache != 0 || aw_if.prot != 0 || aw_if.qos != 0 ||
                    aw_if.region != 0 || aw_if.id != 0 || aw_if.user != 0) viol++;
            end
            if (w_if.valid) begin
                w_vcyc++;
                if (w_if.last !== 1'b1 || w_if.user != 0) viol++;
            end
            if (ar_if.valid) begin
                if (ar_if.len != 0 || ar_if.size != 3'd4 || ar_if.burst != 2'b01 || ar_if.addr[3:0] != 0 ||
                    ar_if.lock || ar_if.cache != 0 || ar_if.prot != 0 || ar_if.qos != 0 ||
                    ar_if.region != 0 || ar_if.id != 0 || ar_if.user != 0) viol++;
            end
            aw_if.ready = aw_if.valid && (aw_wait >= aw_delay);
            aw_wait     = (aw_if.valid && !aw_if.ready) ? aw_wait + 1 : 0;
            w_if.ready  = w_if.valid && (w_wait >= w_delay);
            w_wait      = (w_if.valid && !w_if.ready) ? w_wait + 1 : 0;
            ar_if.ready = ar_if.valid && (ar_wait >= ar_delay);
            ar_wait     = (ar_if.valid && !ar_if.ready) ? ar_wait + 1 : 0;
            aw_vq = aw_if.valid; aw_addr_q = aw_if.addr;
            w_vq  = w_if.valid;  wd_q = w_if.data; ws_q = w_if.strb;
            ar_vq = ar_if.valid; ar_addr_q = ar_if.addr;
            b_rq  = b_if.ready;  r_rq = r_if.ready;
        end
    end

    // Runs one request; lat counts cycles from acceptance to first rsp_valid.
    task automatic do_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          input logic [SW-1:0] st, input int hold,
                          output logic [DW-1:0] rd, output logic er, output int lat,
                          output logic ok, output logic stable, output int unsigned acc_cyc);
        int waitc;
        ok = 1; stable = 1; lat = 0; rd = '0; er = 0; acc_cyc = 0; waitc = 0;
        req_valid = 1; req_we = we; req_addr = addr; req_wdata = wd; req_strb = st;
        while (!req_ready && waitc < 50) begin @(posedge clk); #1; waitc++; end
        if (!req_ready) begin ok = 0; req_valid = 0; return; end
        @(posedge clk); #1;
        acc_cyc = cyc; req_valid = 0; lat = 1;
        while (!rsp_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        if (!rsp_valid) begin ok = 0; return; end
        rd = rsp_rdata; er = rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b1 || rsp_rdata !== rd || rsp_err !== er || req_ready !== 1'b0) stable = 0;
        end
        rsp_ready = 1; @(posedge clk); #1; rsp_ready = 0;
        $display("txn we=%0d addr=%h strb=%h rdata=%h err=%0d lat=%0d", we, addr, st, rd, er, lat);
    endtask

    logic [DW-1:0] rd;
    logic er, ok, stable;
    int lat;
    int unsigned acc1, acc2;

    task automatic test_reset();
        rstn = 0; repeat (3) @(posedge clk); #1;
        n_cmp++; if ({aw_if.valid, w_if.valid, ar_if.valid} !== 3'b000) begin n_bad++;
            $display("FAIL reset_axvalid got=%b want=000", {aw_if.valid, w_if.valid, ar_if.valid}); end
        n_cmp++; if ({b_if.ready, r_if.ready, rsp_valid, rsp_err} !== 4'b0000) begin n_bad++;
            $display("FAIL reset_ready_rsp got=%b want=0000", {b_if.ready, r_if.ready, rsp_valid, rsp_err}); end
        n_cmp++; if (rsp_rdata !== '0) begin n_bad++; $display("FAIL reset_rdata got=%h want=0", rsp_rdata); end
        rstn = 1; @(posedge clk); #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
    endtask

    task automatic test_write_read();
        logic [DW-1:0] d;
        d = {16{8'hA5}};
        do_txn(1, 16'h0010, d, '1, 0, rd, er, lat, ok, stable, acc1);
        ref_write(16'h0010, d, '1);
        n_cmp++; if (!ok || er !== 0 || rd !== '0) begin n_bad++;
            $display("FAIL wr_rsp ok=%0d err=%0d rdata=%h want ok=1 err=0 rdata=0", ok, er, rd); end
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL wr_latency got=%0d want=3", lat); end
        n_cmp++; if (last_aw_addr !== 16'h0010) begin n_bad++; $display("FAIL wr_awaddr got=%h want=0010", last_aw_addr); end
        do_txn(0, 16'h0010, '0, '0, 0, rd, er, lat, ok, stable, acc1);
        n_cmp++; if (!ok || er !== 0 || rd !== {16{8'hA5}}) begin n_bad++;
            $display("FAIL rd_data ok=%0d err=%0d got=%h want=%h", ok, er, rd, {16{8'hA5}}); end
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL rd_latency got=%0d want=3", lat); end
    endtask

    task automatic test_strobe();
        logic [DW-1:0] d;
        d = {$urandom, $urandom, $urandom, $urandom};
        d[7:0] = 8'hFF;
        do_txn(1, 16'h0020, d, 16'h0001, 0, rd, er, lat, ok, stable, acc1);
        ref_write(16'h0020, d, 16'h0001);
        do_txn(0, 16'h0020, '0, '0, 0, rd, er, lat, ok, stable, acc1);
        n_cmp++; if (!ok || rd !== 128'hFF || rd !== ref_mem[2]) begin n_bad++;
            $display("FAIL strobe_byte0 got=%h want=%h", rd, ref_mem[2]); end
    endtask

    task automatic test_unaligned();
        logic [DW-1:0] d;
        d = {$urandom, $urandom, $urandom, $urandom};
        do_txn(1, 16'h0013, d, '1, 0, rd, er, lat, ok, stable, acc1);
        ref_write(16'h0013, d, '1);
        n_cmp++; if (last_aw_addr !== 16'h0010) begin n_bad++; $display("FAIL unaligned_aw got=%h want=0010", last_aw_addr); end
        do_txn(0, 16'h001F, '0, '0, 0, rd, er, lat, ok, stable, acc1);
        n_cmp++; if (last_ar_addr !== 16'h0010 || rd !== ref_mem[1]) begin n_bad++;
            $display("FAIL unaligned_ar addr=%h data=%h want addr=0010 data=%h", last_ar_addr, rd, ref_mem[1]); end
    endtask

    task automatic test_aw_delay();
        int unsigned w0, wv0, awv0, b0;
        logic [DW-1:0] d;
        d = {$urandom, $urandom, $urandom, $urandom};
        w0 = n_w; wv0 = w_vcyc; awv0 = aw_vcyc; b0 = n_b;
        aw_delay = 3;
        do_txn(1, 16'h0040, d, '1, 0, rd, er, lat, ok, stable, acc1);
        aw_delay = 0;
        ref_write(16'h0040, d, '1);
        n_cmp++; if (n_w - w0 !== 1 || w_vcyc - wv0 !== 1) begin n_bad++;
            $display("FAIL awdly_w beats=%0d vcyc=%0d want 1/1", n_w - w0, w_vcyc - wv0); end
        n_cmp++; if (aw_vcyc - awv0 !== 4 || n_b - b0 !== 1) begin n_bad++;
            $display("FAIL awdly_aw vcyc=%0d b=%0d want 4/1", aw_vcyc - awv0, n_b - b0); end
        n_cmp++; if (!ok || er !== 0 || lat !== 6) begin n_bad++;
            $display("FAIL awdly_rsp ok=%0d err=%0d lat=%0d want 1/0/6", ok, er, lat); end
    endtask

    task automatic test_errors();
        logic [1:0] resps [4];
        logic       exp_err [4];
        resps[0] = RESP_SLVERR; resps[1] = RESP_EXOKAY; resps[2] = RESP_DECERR; resps[3] = RESP_OKAY;
        exp_err[0] = 1; exp_err[1] = 0; exp_err[2] = 1; exp_err[3] = 0;
        for (int i = 0; i < 4; i++) begin
            b_resp_cfg = resps[i];
            do_txn(1, 16'h0100, 128'h1, '1, 0, rd, er, lat, ok, stable, acc1);
            ref_write(16'h0100, 128'h1, '1);
            n_cmp++; if (!ok || er !== exp_err[i]) begin n_bad++;
                $display("FAIL b_resp_err resp=%b got=%0d want=%0d", resps[i], er, exp_err[i]); end
        end
        b_resp_cfg = RESP_OKAY; b_id_cfg = 1;
        do_txn(1, 16'h0100, 128'h1, '1, 0, rd, er, lat, ok, stable, acc1);
        b_id_cfg = 0;
        n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL b_id_err got=%0d want=1", er); end
        r_last_cfg = 0;
        do_txn(0, 16'h0010, '0, '0, 0, rd, er, lat, ok, stable, acc1);
        r_last_cfg = 1;
        n_cmp++; if (er !== 1'b1 || rd !== ref_mem[1]) begin n_bad++;
            $display("FAIL r_last_err err=%0d data=%h want 1/%h", er, rd, ref_mem[1]); end
        r_resp_cfg = RESP_SLVERR;
        do_txn(0, 16'h0010, '0, '0, 0, rd, er, lat, ok, stable, acc1);
        r_resp_cfg = RESP_OKAY;
        n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL r_slverr got=%0d want=1", er); end
    endtask

    task automatic test_rsp_stall();
        do_txn(0, 16'h0040, '0, '0, 5, rd, er, lat, ok, stable, acc1);
        n_cmp++; if (!ok || stable !== 1'b1 || rd !== ref_mem[4]) begin n_bad++;
            $display("FAIL rsp_stall stable=%0d data=%h want 1/%h", stable, rd, ref_mem[4]); end
    endtask

    task automatic test_back_to_back();
        do_txn(1, 16'h0050, 128'h55, '1, 0, rd, er, lat, ok, stable, acc1);
        ref_write(16'h0050, 128'h55, '1);
        do_txn(0, 16'h0050, '0, '0, 0, rd, er, lat, ok, stable, acc2);
        n_cmp++; if (acc2 - acc1 !== 4 || rd !== ref_mem[5]) begin n_bad++;
            $display("FAIL b2b_spacing got=%0d data=%h want 4/%h", acc2 - acc1, rd, ref_mem[5]); end
    endtask

    task automatic test_reset_mid();
        int waitc;
        r_hold = 1; req_valid = 1; req_we = 0; req_addr = 16'h0040; waitc = 0;
        @(posedge clk); #1; req_valid = 0;
        while (!r_if.ready && waitc < 20) begin @(posedge clk); #1; waitc++; end
        n_cmp++; if (r_if.ready !== 1'b1) begin n_bad++; $display("FAIL mid_reach_rd_r got=%b want=1", r_if.ready); end
        rstn = 0; @(posedge clk); #1;
        n_cmp++; if ({aw_if.valid, w_if.valid, ar_if.valid, b_if.ready, r_if.ready, rsp_valid} !== 6'b0) begin n_bad++;
            $display("FAIL mid_reset_outputs got=%b want=000000",
                     {aw_if.valid, w_if.valid, ar_if.valid, b_if.ready, r_if.ready, rsp_valid}); end
        rstn = 1; r_hold = 0; @(posedge clk); #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL mid_req_ready got=%b want=1", req_ready); end
        do_txn(0, 16'h0040, '0, '0, 0, rd, er, lat, ok, stable, acc1);
        n_cmp++; if (!ok || rd !== ref_mem[4] || er !== 0) begin n_bad++;
            $display("FAIL mid_recover data=%h err=%0d want %h/0", rd, er, ref_mem[4]); end
    endtask

    task automatic test_random();
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d, exp;
        logic [SW-1:0] s;
        for (int t = 0; t < 30; t++) begin
            aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3); ar_delay = $urandom_range(0, 3);
            we = 1'($urandom);
            a  = {8'h00, 4'($urandom_range(0, 15)), 4'($urandom)};
            d  = {$urandom, $urandom, $urandom, $urandom};
            s  = 16'($urandom);
            do_txn(we, a, d, s, $urandom_range(0, 2), rd, er, lat, ok, stable, acc1);
            if (we) begin
                ref_write(a, d, s);
                exp = '0;
            end else begin
                exp = ref_mem[a[15:4]];
            end
            n_cmp++; if (!ok || er !== 0 || rd !== exp || stable !== 1'b1) begin n_bad++;
                $display("FAIL random_txn t=%0d we=%0d addr=%h got=%h err=%0d want=%h err=0", t, we, a, rd, er, exp); end
        end
        aw_delay = 0; w_delay = 0; ar_delay = 0;
        n_cmp++; if (viol !== 0) begin n_bad++; $display("FAIL sideband_fields violations=%0d want=0", viol); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_strobe();
        test_unaligned();
        test_aw_delay();
        test_errors();
        test_rsp_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
